// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bus interface.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_rd_align.sv
// Right-aligns a bus read word by the access byte offset so that byte and
// halfword extraction downstream always reads from the low lanes.
module dmem_rd_align #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    off,
  output logic [DW-1:0] data
);

  always_comb begin
    data = rdata >> {off, 3'b000};
  end

endmodule

// File: rtl/dmem_bus_if.sv
// LSU-to-bus bridge: latches one access, runs a valid/ready request plus
// response phase, stalls the pipeline meanwhile and returns aligned read data.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_bus_if
  import dmem_bus_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_be,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_rd,
`ifdef DMEM_MISALIGN_TRAP_EN
  input  logic          ld_word,
`endif
  output logic [DW-1:0] rd_data,
  output logic          stall,
  output logic          bus_err,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic [AW-1:0] bus_addr,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_rsp_valid,
  input  logic [DW-1:0] bus_rsp_rdata,
  input  logic          bus_rsp_err
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  dmem_state_e   state_q, state_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]    off_q, off_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          acc;
  logic          is_store;
  logic          misalign;
  logic [DW-1:0] rsp_aligned;

  always_comb begin
    is_store = (cpu_be != 4'b0000);
    acc      = cpu_rd | is_store;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = (cpu_addr[1:0] != 2'b00) &&
               ((cpu_rd && ld_word && !is_store) || (cpu_be == BE_WORD));
  end
`else
  always_comb begin
    misalign = 1'b0;
  end
`endif

  dmem_rd_align #(.DW(DW)) u_rd_align (
    .rdata (bus_rsp_rdata),
    .off   (off_q),
    .data  (rsp_aligned)
  );

  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_we_d      = bus_we_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    off_d         = off_q;
    rd_data_d     = rd_data_q;
    bus_err_d     = 1'b0;
    cnt_d         = cnt_q;
    stall         = 1'b0;
    bus_req_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          stall = 1'b1;
          if (misalign) begin
            state_d   = DONE;
            rd_data_d = '0;
            bus_err_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_addr_d  = {cpu_addr[AW-1:2], 2'b00};
            bus_we_d    = is_store;
            bus_be_d    = is_store ? cpu_be : BE_WORD;
            bus_wdata_d = cpu_wdata;
            off_d       = cpu_addr[1:0];
          end
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        stall = 1'b1;
        // Counter value k means k cycles already spent here without a response.
        if (bus_rsp_valid) begin
          state_d   = DONE;
          rd_data_d = bus_we_q ? '0 : rsp_aligned;
          bus_err_d = bus_rsp_err;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = DONE;
          rd_data_d = '0;
          bus_err_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      rd_data_q   <= '0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      rd_data_q   <= rd_data_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    bus_addr  = bus_addr_q;
    bus_we    = bus_we_q;
    bus_be    = bus_be_q;
    bus_wdata = bus_wdata_q;
    rd_data   = rd_data_q;
    bus_err   = bus_err_q;
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Randomized self-checking bench for dmem_bus_if against a transaction-level model.
module tb_dmem_bus_if;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        cpu_rd;
  logic [31:0] rd_data;
  logic        stall;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  dmem_bus_if #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_be        (cpu_be),
    .cpu_wdata     (cpu_wdata),
    .cpu_rd        (cpu_rd),
    .rd_data       (rd_data),
    .stall         (stall),
    .bus_err       (bus_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    int unsigned rdy;    // REQ cycles before ready
    int unsigned rsp;    // RESP cycles before response
    logic [31:0] rdata;
    logic        err;
    logic        tmo;    // slave never responds
    logic        b2b;    // next access presented in this one's DONE cycle
  } txn_t;

  txn_t q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic rd,
                              input int unsigned rdy, input int unsigned rsp,
                              input logic [31:0] rdata, input logic err,
                              input logic tmo, input logic b2b);
    txn_t t;
    t.addr = addr; t.be = be; t.wdata = wdata; t.rd = rd; t.rdy = rdy; t.rsp = rsp;
    t.rdata = rdata; t.err = err; t.tmo = tmo; t.b2b = b2b;
    return t;
  endfunction

  task automatic drive_cpu(input txn_t t);
    cpu_addr = t.addr; cpu_be = t.be; cpu_wdata = t.wdata; cpu_rd = t.rd;
  endtask

  task automatic clear_cpu();
    cpu_addr = '0; cpu_be = '0; cpu_wdata = '0; cpu_rd = 1'b0;
  endtask

  task automatic scramble_cpu();
    cpu_addr = $urandom; cpu_be = 4'($urandom); cpu_wdata = $urandom; cpu_rd = 1'($urandom);
  endtask

  // Called at posedge+1 with the DUT in IDLE.
  task automatic run_txn(input txn_t t, input bit apply, input bit have_next, input txn_t nx);
    int unsigned stalls;
    int unsigned n_resp;
    int unsigned e_stalls;
    logic [31:0] e_addr, e_rd;
    logic [3:0]  e_be;
    logic        e_err, e_we;
    stalls   = 0;
    e_we     = (t.be != 4'd0);
    e_addr   = t.addr - (t.addr % 4);
    e_be     = e_we ? t.be : 4'hF;
    n_resp   = t.tmo ? TMO : t.rsp + 1;
    e_err    = t.tmo ? 1'b1 : t.err;
    e_rd     = (t.tmo || e_we) ? 32'd0 : t.rdata / (32'd1 << (8 * (t.addr % 4)));
    e_stalls = 1 + (t.rdy + 1) + n_resp;

    if (apply) begin
      #1;
      check_eq("idle_req_valid", bus_req_valid, 0);
      check_eq("idle_stall", stall, 0);
      drive_cpu(t);
    end
    bus_req_ready = 1'($urandom); bus_rsp_valid = 1'($urandom);
    bus_rsp_rdata = $urandom;     bus_rsp_err   = 1'($urandom);
    #1;
    check_eq("acc_stall", stall, 1);
    if (stall) stalls++;
    @(posedge clk); #1;

    for (int unsigned i = 0; i <= t.rdy; i++) begin
      scramble_cpu();
      bus_req_ready = (i == t.rdy);
      bus_rsp_valid = 1'($urandom); bus_rsp_rdata = $urandom; bus_rsp_err = 1'($urandom);
      #1;
      check_eq("req_valid", bus_req_valid, 1);
      check_eq("req_addr", bus_addr, e_addr);
      check_eq("req_we", bus_we, e_we);
      check_eq("req_be", bus_be, e_be);
      check_eq("req_wdata", bus_wdata, t.wdata);
      if (stall) stalls++;
      @(posedge clk); #1;
    end

    for (int unsigned i = 0; i < n_resp; i++) begin
      scramble_cpu();
      bus_req_ready = 1'($urandom);
      bus_rsp_valid = !t.tmo && (i == t.rsp);
      bus_rsp_rdata = bus_rsp_valid ? t.rdata : $urandom;
      bus_rsp_err   = bus_rsp_valid ? t.err : 1'($urandom);
      #1;
      if (i == 0) check_eq("resp_req_valid", bus_req_valid, 0);
      if (stall) stalls++;
      @(posedge clk); #1;
    end

    if (have_next) drive_cpu(nx); else clear_cpu();
    bus_req_ready = 1'($urandom); bus_rsp_valid = 1'($urandom);
    bus_rsp_rdata = $urandom;     bus_rsp_err   = 1'($urandom);
    #1;
    check_eq("done_stall", stall, 0);
    check_eq("done_req_valid", bus_req_valid, 0);
    check_eq("done_rd_data", rd_data, e_rd);
    check_eq("done_bus_err", bus_err, e_err);
    check_eq("stall_cycles", stalls, e_stalls);
    @(posedge clk); #1;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    check_eq("err_clear", bus_err, 0);
  endtask

  initial begin
    txn_t t, nx, dummy;
    bit   apply;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    clear_cpu();
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_req_valid", bus_req_valid, 0);
    check_eq("rst_addr", bus_addr, 0);
    check_eq("rst_we", bus_we, 0);
    check_eq("rst_be", bus_be, 0);
    check_eq("rst_wdata", bus_wdata, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_stall", stall, 0);

    q.push_back(mk(32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 0, 0));
    q.push_back(mk(32'h203, 4'h0, 32'h0, 1, 0, 0, 32'hA5112233, 0, 0, 0));
    q.push_back(mk(32'h302, 4'h0, 32'h0, 1, 3, 4, 32'hA5110000, 0, 0, 0));
    q.push_back(mk(32'h600, 4'h0, 32'h0, 1, 0, 1, 32'h01020304, 0, 0, 1));
    q.push_back(mk(32'h604, 4'h3, 32'h0000CAFE, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0));
    q.push_back(mk(32'h701, 4'h0, 32'h0, 1, 1, 0, 32'h0, 0, 1, 0));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        t = mk($urandom, 4'h0, $urandom, 1, $urandom_range(0, 3), $urandom_range(0, 4),
               $urandom, ($urandom_range(0, 7) == 0), 0, 1'($urandom));
      else
        t = mk($urandom, 4'($urandom_range(1, 15)), $urandom, 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom,
               ($urandom_range(0, 7) == 0), 0, 1'($urandom));
      q.push_back(t);
    end
    q[q.size()-1].b2b = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      apply = (i == 0) || !q[i-1].b2b;
      nx    = q[i].b2b ? q[i+1] : dummy;
      run_txn(q[i], apply, q[i].b2b, nx);
    end

    // Reset during RESP after a load that left nonzero rd_data behind.
    run_txn(mk(32'h501, 4'h0, 32'h0, 1, 0, 0, 32'h12345678, 0, 0, 0), 1'b1, 1'b0, dummy);
    check_eq("pre_rst_rd_data", rd_data, 32'h00123456);
    drive_cpu(mk(32'h404, 4'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    clear_cpu();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_req_valid", bus_req_valid, 0);
    check_eq("midrst_rd_data", rd_data, 0);
    check_eq("midrst_addr", bus_addr, 0);
    check_eq("midrst_stall", stall, 0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFFFFFF; bus_rsp_err = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    check_eq("late_rsp_rd_data", rd_data, 0);
    check_eq("late_rsp_bus_err", bus_err, 0);
    check_eq("late_rsp_stall", stall, 0);
    check_eq("late_rsp_req_valid", bus_req_valid, 0);
    @(posedge clk); #1;
    check_eq("late_rsp_err_after", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
